// File: rtl/uart_fifo_transmitter.sv
// rtl/uart_fifo_transmitter.sv - drains the TX FIFO read port and serialises words as async UART frames
// Optional parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_fifo_transmitter #(
  parameter int DATA_BITS   = 8,
  parameter int SCALE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [SCALE_WIDTH-1:0] clock_scale,
`ifdef UART_TX_PARITY_EN
  input  logic                   parity_odd,
`endif
  input  logic [DATA_BITS-1:0]   fifo_data,
  input  logic                   fifo_is_data,
  output logic                   fifo_oe,
  output logic                   tx,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int CNT_WIDTH = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state, stateNext;
  logic [DATA_BITS-1:0]   shiftReg, shiftNext;
  logic [CNT_WIDTH-1:0]   bitCnt, bitCntNext;
  logic [SCALE_WIDTH-1:0] baudCnt, baudNext;
  logic [SCALE_WIDTH-1:0] scaleReg, scaleNext;
  logic                   txNext, busyNext, oeNext, doneNext;
  logic                   bitEnd, startFrame, launch;
`ifdef UART_TX_PARITY_EN
  // Running parity: seeded with parity_odd, XORed with every data bit as it is sent.
  logic                   parityAcc, parityNext;
`endif

  assign bitEnd     = (baudCnt == '0);
  assign startFrame = enable && fifo_is_data;

  // State and registered outputs; reset drops any frame in flight and idles the line high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shiftReg   <= '0;
      bitCnt     <= '0;
      baudCnt    <= '0;
      scaleReg   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_oe    <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parityAcc  <= 1'b0;
`endif
    end else begin
      state      <= stateNext;
      shiftReg   <= shiftNext;
      bitCnt     <= bitCntNext;
      baudCnt    <= baudNext;
      scaleReg   <= scaleNext;
      tx         <= txNext;
      busy       <= busyNext;
      fifo_oe    <= oeNext;
      frame_done <= doneNext;
`ifdef UART_TX_PARITY_EN
      parityAcc  <= parityNext;
`endif
    end
  end

  // Next-state and next-output logic; a frame launch (from IDLE or back-to-back from STOP) pops the FIFO head.
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    baudNext   = baudCnt;
    scaleNext  = scaleReg;
    txNext     = tx;
    busyNext   = busy;
    oeNext     = 1'b0;
    doneNext   = 1'b0;
    launch     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parityNext = parityAcc;
`endif

    case (state)
      IDLE: begin
        txNext   = 1'b1;
        busyNext = 1'b0;
        if (startFrame) begin
          launch = 1'b1;
        end
      end

      START: begin
        if (bitEnd) begin
          stateNext  = DATA;
          txNext     = shiftReg[0];
          shiftNext  = shiftReg >> 1;
          bitCntNext = '0;
          baudNext   = scaleReg;
`ifdef UART_TX_PARITY_EN
          parityNext = parityAcc ^ shiftReg[0];
`endif
        end else begin
          baudNext = baudCnt - SCALE_WIDTH'(1);
        end
      end

      DATA: begin
        if (bitEnd) begin
          baudNext = scaleReg;
          if (bitCnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            stateNext = PARITY;
            txNext    = parityAcc;
`else
            stateNext = STOP;
            txNext    = 1'b1;
`endif
          end else begin
            bitCntNext = bitCnt + CNT_WIDTH'(1);
            txNext     = shiftReg[0];
            shiftNext  = shiftReg >> 1;
`ifdef UART_TX_PARITY_EN
            parityNext = parityAcc ^ shiftReg[0];
`endif
          end
        end else begin
          baudNext = baudCnt - SCALE_WIDTH'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitEnd) begin
          stateNext = STOP;
          txNext    = 1'b1;
          baudNext  = scaleReg;
        end else begin
          baudNext = baudCnt - SCALE_WIDTH'(1);
        end
      end
`endif

      STOP: begin
        if (bitEnd) begin
          doneNext = 1'b1;
          if (startFrame) begin
            launch = 1'b1;
          end else begin
            stateNext = IDLE;
            busyNext  = 1'b0;
          end
        end else begin
          baudNext = baudCnt - SCALE_WIDTH'(1);
        end
      end

      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
        busyNext  = 1'b0;
      end
    endcase

    // Frame launch: capture head word, pop it, drive the start bit and latch the baud divisor.
    if (launch) begin
      stateNext  = START;
      shiftNext  = fifo_data;
      oeNext     = 1'b1;
      txNext     = 1'b0;
      busyNext   = 1'b1;
      bitCntNext = '0;
      scaleNext  = clock_scale;
      baudNext   = clock_scale;
`ifdef UART_TX_PARITY_EN
      parityNext = parity_odd;
`endif
    end
  end

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// tb/tb_uart_fifo_transmitter.sv - scoreboard bench for uart_fifo_transmitter (parity under UART_TX_PARITY_EN)
module tb_uart_fifo_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [15:0] clock_scale = 16'd3;
  logic [7:0]  fifo_data;
  logic        fifo_is_data;
  logic        fifo_oe, tx, busy, frame_done;
`ifdef UART_TX_PARITY_EN
  logic        parity_odd = 1'b0;
  logic        parityQ = 1'b0;
`endif

  uart_fifo_transmitter #(.DATA_BITS(8), .SCALE_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clock_scale  (clock_scale),
`ifdef UART_TX_PARITY_EN
    .parity_odd   (parity_odd),
`endif
    .fifo_data    (fifo_data),
    .fifo_is_data (fifo_is_data),
    .fifo_oe      (fifo_oe),
    .tx           (tx),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else nPass++;
  endtask

  // FIFO model: combinational head, pop sampled on posedge and applied on the following negedge.
  logic [7:0] fifoMem [0:15];
  int         head = 0;
  int         tail = 0;
  int         popCount = 0;
  logic [7:0] expQ [$];
  logic       rstQ = 1'b1;
  logic       oeSeen = 1'b0;
  logic [15:0] scaleQ = 16'd0;

  assign fifo_is_data = (head != tail);
  assign fifo_data    = fifoMem[head[3:0]];

  always @(posedge clk) begin
    rstQ   <= rst;
    oeSeen <= fifo_oe;
    scaleQ <= clock_scale;
`ifdef UART_TX_PARITY_EN
    parityQ <= parity_odd;
`endif
  end

  always @(negedge clk) begin
    if (oeSeen) begin
      head = head + 1;
      popCount = popCount + 1;
    end
  end

  // Line monitor: decodes each frame against the scoreboard head, cycle by cycle.
  logic        monActive = 1'b0;
  int          cyc = 0;
  int          scaleCur = 0;
  int          framesDone = 0;
  logic [10:0] expBits = '1;

  always @(negedge clk) begin : monitor
    logic       endCycle;
    logic [7:0] d;
    int         bitIdx;
    if (rstQ) begin
      monActive = 1'b0;
      checkVal("rst_tx", tx, 1);
      checkVal("rst_busy", busy, 0);
      checkVal("rst_oe", fifo_oe, 0);
      checkVal("rst_done", frame_done, 0);
    end else begin
      endCycle = 1'b0;
      if (monActive && cyc == FRAME_BITS * (scaleCur + 1)) begin
        checkVal("frame_done_end", frame_done, 1);
        monActive = 1'b0;
        framesDone++;
        endCycle = 1'b1;
      end
      if (!monActive) begin
        if (tx == 1'b0) begin
          if (expQ.size() == 0) begin
            checkVal("unexpected_frame", 0, 1);
            d = 8'h00;
          end else begin
            d = expQ.pop_front();
          end
          scaleCur = int'(scaleQ);
          expBits = '1;
          expBits[0] = 1'b0;
          for (int i = 0; i < 8; i++) expBits[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
          expBits[9] = (^d) ^ parityQ;
`endif
          cyc = 0;
          monActive = 1'b1;
        end else begin
          checkVal("idle_tx", tx, 1);
          checkVal("idle_oe", fifo_oe, 0);
          checkVal("idle_busy", busy, 0);
          if (!endCycle) checkVal("idle_done", frame_done, 0);
        end
      end
      if (monActive) begin
        bitIdx = cyc / (scaleCur + 1);
        checkVal($sformatf("tx_bit%0d", bitIdx), tx, expBits[bitIdx]);
        checkVal("frame_oe", fifo_oe, (cyc == 0) ? 1 : 0);
        checkVal("frame_busy", busy, 1);
        if (!endCycle) checkVal("frame_done_mid", frame_done, 0);
        cyc++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifoMem[tail[3:0]] = b;
    tail = tail + 1;
    expQ.push_back(b);
  endtask

  task automatic waitIdle(input string tag);
    logic hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      tick();
      if (!monActive && head == tail && !busy) hit = 1'b1;
    end
    checkVal({tag, "_reached_idle"}, hit, 1);
  endtask

  task automatic waitFrameCycle(input string tag, input int target);
    logic hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      tick();
      if (monActive && cyc == target) hit = 1'b1;
    end
    checkVal({tag, "_reached_cycle"}, hit, 1);
  endtask

  initial begin : stimulus
    int busyCnt;
    for (int i = 0; i < 16; i++) fifoMem[i] = 8'h00;

    // Reset held 3 cycles with data queued: no pop, line idle.
    pushByte(8'hA5);
    repeat (3) tick();
    checkVal("rst_no_pop", popCount, 0);
    rst = 1'b0;
    waitIdle("a5");
    checkVal("a5_pops", popCount, 1);

    // Three bytes back-to-back at one cycle per bit.
    enable = 1'b0;
    clock_scale = 16'd0;
    pushByte(8'h01);
    pushByte(8'h80);
    pushByte(8'hFF);
    tick();
    enable = 1'b1;
    busyCnt = 0;
    for (int i = 0; i < 10 && !busy; i++) tick();
    while (busy && busyCnt < 200) begin
      busyCnt++;
      tick();
    end
    checkVal("b2b_busy_cycles", busyCnt, 3 * FRAME_BITS);
    waitIdle("b2b");
    checkVal("b2b_pops", popCount, 4);

    // Empty FIFO with enable high, then data arrives.
    repeat (100) tick();
    checkVal("empty_no_pop", popCount, 4);
    pushByte(8'h3C);
    tick();
    checkVal("start_tx_low", tx, 0);
    checkVal("start_oe", fifo_oe, 1);
    waitIdle("late");
    checkVal("late_pops", popCount, 5);

    // enable dropped during bit 3 with two bytes queued.
    enable = 1'b0;
    clock_scale = 16'd1;
    pushByte(8'h5A);
    pushByte(8'hC3);
    tick();
    enable = 1'b1;
    waitFrameCycle("en_drop", 3 * 2);
    enable = 1'b0;
    repeat (60) tick();
    checkVal("en_drop_pops", popCount, 6);
    checkVal("en_drop_queued", fifo_is_data, 1);
    enable = 1'b1;
    waitIdle("reenable");
    checkVal("reenable_pops", popCount, 7);

    // Reset mid-DATA aborts the frame; the next byte goes out intact.
    clock_scale = 16'd2;
    pushByte(8'h96);
    pushByte(8'h07);
    waitFrameCycle("rst_mid", 5 * 3);
    rst = 1'b1;
    tick();
    checkVal("rst_mid_tx", tx, 1);
    checkVal("rst_mid_busy", busy, 0);
    rst = 1'b0;
    waitIdle("after_rst");
    checkVal("after_rst_pops", popCount, 9);

    checkVal("scoreboard_empty", expQ.size(), 0);
    checkVal("frames_completed", framesDone, 8);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
